// File: rtl/concat_stream_merge.sv
// Circular frame buffer of layer pixels, merged in order with branch pixels into one wide word.
// Accepted pop -> merged word valid two cycles later; no backpressure, errors are flagged and sticky.
module concat_stream_merge #(
    parameter int N           = 8,
    parameter int LAYER_CH    = 1,
    parameter int BRANCH_CH   = 1,
    parameter int INPUT_SIZE  = 1,
    parameter int BRANCH_HIGH = 1,
    parameter int ADDR_WIDTH  = $clog2(INPUT_SIZE*INPUT_SIZE+1)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clr,
    input  logic                                layer_vld,
    input  logic [LAYER_CH*N-1:0]               layer_din,
    input  logic                                branch_vld,
    input  logic [BRANCH_CH*N-1:0]              branch_din,
    output logic                                concat_dout_vld,
    output logic [(LAYER_CH+BRANCH_CH)*N-1:0]   concat_dout,
    output logic                                frame_done,
    output logic [ADDR_WIDTH-1:0]               fill_level,
    output logic                                overflow,
    output logic                                underflow
);
    localparam int FRAME_PIX = INPUT_SIZE*INPUT_SIZE;
    localparam int LW        = LAYER_CH*N;
    localparam int BW        = BRANCH_CH*N;
    localparam int OW        = LW + BW;
    localparam int IDX_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_PIX-1);
    localparam logic [ADDR_WIDTH-1:0] FULL = ADDR_WIDTH'(FRAME_PIX);

    logic [LW-1:0]         mem [FRAME_PIX];
    logic [LW-1:0]         layer_rd_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] fill_q, fill_d, frm_cnt_q, frm_cnt_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic [BW-1:0]         s1_branch_q, s1_branch_d;
    logic                  vld_q, vld_d, done_q, done_d;
    logic [OW-1:0]         dout_q, dout_d, merged;
    logic                  push_ok, pop_ok;

    function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    // Fullness is judged on the registered fill only, so an empty buffer never bypasses a same-cycle push.
    assign push_ok = layer_vld  && (fill_q != FULL);
    assign pop_ok  = branch_vld && (fill_q != '0);
    assign merged  = (BRANCH_HIGH != 0) ? {s1_branch_q, layer_rd_q} : {layer_rd_q, s1_branch_q};

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        frm_cnt_d   = frm_cnt_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        s1_vld_d    = pop_ok;
        s1_last_d   = (frm_cnt_q == LAST);
        s1_branch_d = pop_ok ? branch_din : s1_branch_q;
        vld_d       = s1_vld_q;
        done_d      = s1_vld_q && s1_last_q;
        dout_d      = s1_vld_q ? merged : dout_q;
        if (push_ok) wr_ptr_d = ptr_next(wr_ptr_q);
        if (layer_vld && !push_ok) ovf_d = 1'b1;
        if (pop_ok) begin
            rd_ptr_d  = ptr_next(rd_ptr_q);
            frm_cnt_d = ptr_next(frm_cnt_q);
        end
        if (branch_vld && !pop_ok) unf_d = 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   fill_d = fill_q + ADDR_WIDTH'(1);
            2'b01:   fill_d = fill_q - ADDR_WIDTH'(1);
            default: fill_d = fill_q;
        endcase
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fill_d      = '0;
            frm_cnt_d   = '0;
            ovf_d       = 1'b0;
            unf_d       = 1'b0;
            s1_vld_d    = 1'b0;
            s1_last_d   = 1'b0;
            s1_branch_d = '0;
            vld_d       = 1'b0;
            done_d      = 1'b0;
            dout_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            frm_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_branch_q <= '0;
            vld_q       <= 1'b0;
            done_q      <= 1'b0;
            dout_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            frm_cnt_q   <= frm_cnt_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            s1_branch_q <= s1_branch_d;
            vld_q       <= vld_d;
            done_q      <= done_d;
            dout_q      <= dout_d;
        end
    end

    // Storage and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr_q[IDX_W-1:0]] <= layer_din;
        if (pop_ok) layer_rd_q <= mem[rd_ptr_q[IDX_W-1:0]];
    end

    assign concat_dout_vld = vld_q;
    assign concat_dout     = dout_q;
    assign frame_done      = done_q;
    assign fill_level      = fill_q;
    assign overflow        = ovf_q;
    assign underflow       = unf_q;
endmodule

// File: tb/tb_concat_stream_merge.sv
// Bench for concat_stream_merge: two instances (branch-high and layer-high order) share stimulus
// and are compared every cycle against a queue-based frame-buffer model.
module tb_concat_stream_merge;
    localparam int FP = 4;

    logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic        layer_vld = 1'b0, branch_vld = 1'b0;
    logic [15:0] layer_din = '0;
    logic [7:0]  branch_din = '0;
    logic        vld1, done1, ovf1, unf1, vld0, done0, ovf0, unf0;
    logic [23:0] dout1, dout0;
    logic [2:0]  fill1, fill0;

    always #5 clk = ~clk;

    concat_stream_merge #(.N(8), .LAYER_CH(2), .BRANCH_CH(1), .INPUT_SIZE(2), .BRANCH_HIGH(1)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .layer_vld(layer_vld), .layer_din(layer_din),
        .branch_vld(branch_vld), .branch_din(branch_din), .concat_dout_vld(vld1), .concat_dout(dout1),
        .frame_done(done1), .fill_level(fill1), .overflow(ovf1), .underflow(unf1));

    concat_stream_merge #(.N(8), .LAYER_CH(2), .BRANCH_CH(1), .INPUT_SIZE(2), .BRANCH_HIGH(0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .clr(clr), .layer_vld(layer_vld), .layer_din(layer_din),
        .branch_vld(branch_vld), .branch_din(branch_din), .concat_dout_vld(vld0), .concat_dout(dout0),
        .frame_done(done0), .fill_level(fill0), .overflow(ovf0), .underflow(unf0));

    typedef struct {
        int          due;
        logic [23:0] w_hi;
        logic [23:0] w_lo;
        bit          last;
    } exp_t;

    logic [15:0] store[$];
    exp_t        pend[$];
    int          cyc = 0, pops = 0;
    bit          m_ovf = 1'b0, m_unf = 1'b0;
    logic [23:0] last_hi = '0, last_lo = '0;
    logic [23:0] cap_hi[$], cap_lo[$];
    int          done_cnt = 0;
    int          checks = 0, errors = 0;

    task automatic model_clear();
        store.delete();
        pend.delete();
        pops    = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        last_hi = '0;
        last_lo = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge rst_n) model_clear();

    // Reference: a FIFO of stored pixels; each accepted pop schedules its merged word two cycles
    // after the cycle in which the pop was presented.
    always @(posedge clk) begin
        bit          push_ok, pop_ok;
        logic [15:0] l;
        exp_t        e;
        cyc++;
        if (!rst_n || clr) begin
            model_clear();
        end else begin
            push_ok = layer_vld && (store.size() < FP);
            pop_ok  = branch_vld && (store.size() > 0);
            if (layer_vld && !push_ok) m_ovf = 1'b1;
            if (branch_vld && !pop_ok) m_unf = 1'b1;
            if (pop_ok) begin
                l      = store.pop_front();
                e.due  = (cyc - 1) + 2;
                e.w_hi = {branch_din, l};
                e.w_lo = {l, branch_din};
                e.last = ((pops % FP) == FP - 1);
                pops++;
                pend.push_back(e);
            end
            if (push_ok) store.push_back(layer_din);
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = (pend.size() > 0) && (pend[0].due == cyc);
        chk("vld_hi", 32'(vld1), 32'(ev));
        chk("vld_lo", 32'(vld0), 32'(ev));
        if (ev) begin
            last_hi = pend[0].w_hi;
            last_lo = pend[0].w_lo;
            chk("done_hi", 32'(done1), 32'(pend[0].last));
            chk("done_lo", 32'(done0), 32'(pend[0].last));
            void'(pend.pop_front());
        end else begin
            chk("done_hi", 32'(done1), 32'd0);
            chk("done_lo", 32'(done0), 32'd0);
        end
        chk("dout_hi", 32'(dout1), 32'(last_hi));
        chk("dout_lo", 32'(dout0), 32'(last_lo));
        chk("fill_hi", 32'(fill1), 32'(store.size()));
        chk("fill_lo", 32'(fill0), 32'(store.size()));
        chk("ovf", 32'({ovf1, ovf0}), 32'({m_ovf, m_ovf}));
        chk("unf", 32'({unf1, unf0}), 32'({m_unf, m_unf}));
        if (vld1) cap_hi.push_back(dout1);
        if (vld0) cap_lo.push_back(dout0);
        if (done1) done_cnt++;
    end

    task automatic step(input bit lv, input logic [15:0] ld, input bit bv, input logic [7:0] bd);
        layer_vld  = lv;
        layer_din  = ld;
        branch_vld = bv;
        branch_din = bd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1'b0, '0, 1'b0, '0);
        clr = 1'b0;
    endtask

    task automatic cap_reset();
        cap_hi.delete();
        cap_lo.delete();
        done_cnt = 0;
    endtask

    logic [23:0] s1_hi [4] = '{24'hA00102, 24'hA10304, 24'hA20506, 24'hA30708};
    logic [23:0] s1_lo [4] = '{24'h0102A0, 24'h0304A1, 24'h0506A2, 24'h0708A3};
    logic [15:0] s1_px [4] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    logic [15:0] ov_px [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({vld1, done1, ovf1, unf1, fill1}), 32'd0);
        chk("reset_dout", 32'(dout1), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Fill one frame, then drain it.
        cap_reset();
        for (int i = 0; i < 4; i++) step(1'b1, s1_px[i], 1'b0, '0);
        chk("s1_fill_full", 32'(fill1), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 8'(8'hA0 + i));
        idle(3);
        chk("s1_count_hi", 32'(cap_hi.size()), 32'd4);
        chk("s1_count_lo", 32'(cap_lo.size()), 32'd4);
        for (int i = 0; i < 4 && i < cap_hi.size() && i < cap_lo.size(); i++) begin
            chk("s1_word_hi", 32'(cap_hi[i]), 32'(s1_hi[i]));
            chk("s1_word_lo", 32'(cap_lo[i]), 32'(s1_lo[i]));
        end
        chk("s1_frame_done", 32'(done_cnt), 32'd1);
        chk("s1_fill_empty", 32'(fill1), 32'd0);

        // Streaming through three frames with pointer wrap.
        cap_reset();
        for (int i = 0; i <= 12; i++) begin
            step(i < 12, 16'($urandom), i >= 1, 8'($urandom));
            chk("il_fill_le1", 32'(fill1 <= 3'd1), 32'd1);
        end
        idle(3);
        chk("il_count", 32'(cap_hi.size()), 32'd12);
        chk("il_frame_done", 32'(done_cnt), 32'd3);
        chk("il_no_unf", 32'(unf1), 32'd0);

        // Overflow: fifth push dropped, first four survive.
        cap_reset();
        for (int i = 0; i < 5; i++) step(1'b1, ov_px[i], 1'b0, '0);
        chk("ov_flag", 32'(ovf1), 32'd1);
        chk("ov_fill", 32'(fill1), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 8'h77);
        idle(3);
        chk("ov_count", 32'(cap_hi.size()), 32'd4);
        for (int i = 0; i < 4 && i < cap_hi.size(); i++)
            chk("ov_word", 32'(cap_hi[i]), 32'({8'h77, ov_px[i]}));
        chk("ov_still_set", 32'(ovf1), 32'd1);
        do_clr();
        chk("ov_clr", 32'({ovf1, unf1, fill1}), 32'd0);

        // Underflow with same-cycle push into an empty buffer.
        cap_reset();
        step(1'b1, 16'hBEEF, 1'b1, 8'h55);
        chk("uf_flag", 32'(unf1), 32'd1);
        chk("uf_fill", 32'(fill1), 32'd1);
        idle(2);
        chk("uf_no_vld", 32'(cap_hi.size()), 32'd0);
        step(1'b0, '0, 1'b1, 8'h66);
        idle(2);
        chk("uf_count", 32'(cap_hi.size()), 32'd1);
        if (cap_hi.size() > 0) chk("uf_word", 32'(cap_hi[0]), 32'h66BEEF);
        do_clr();

        // Synchronous clear while a merge is in flight.
        step(1'b1, 16'hC0C0, 1'b0, '0);
        step(1'b1, 16'hC1C1, 1'b0, '0);
        cap_reset();
        step(1'b0, '0, 1'b1, 8'h12);
        do_clr();
        idle(3);
        chk("clr_no_vld", 32'(cap_hi.size()), 32'd0);
        chk("clr_state", 32'({dout1, fill1, ovf1, unf1}), 32'd0);

        // Asynchronous reset mid-cycle while a merge is in flight.
        step(1'b1, 16'hD0D0, 1'b0, '0);
        step(1'b1, 16'hD1D1, 1'b0, '0);
        cap_reset();
        step(1'b0, '0, 1'b1, 8'h34);
        #3 rst_n = 1'b0;
        #1 chk("arst_immediate", 32'({vld1, fill1}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        chk("arst_no_vld", 32'(cap_hi.size()), 32'd0);
        chk("arst_state", 32'({dout1, fill1, ovf1, unf1}), 32'd0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 3000; i++) begin
            clr = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 55, 8'($urandom));
        end
        clr = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
